// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and parity helper for the parametrised UART
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  // Unused upper data bits must be zero so they do not disturb the reduction.
  function automatic logic parity_bit(input logic [7:0] data, input parity_e mode);
    case (mode)
      PAR_ODD:  return ~^data;
      PAR_EVEN: return ^data;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running oversample tick, one pulse every CLK_DIV clocks
module uart_baud_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_core_param.sv
// rtl/uart_core_param.sv - full-duplex UART with configurable framing, 16x RX and RTS/CTS
module uart_core_param
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int FLOW_CTL  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  input  logic                 cts,
  input  logic                 rxd,
  output logic                 rts,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int      BIT_CLKS  = CLK_DIV * OVERSAMPLE;
  localparam int      STOP_CLKS = STOP_BITS * BIT_CLKS;
  localparam int      TCW       = $clog2(STOP_CLKS);
  localparam parity_e PAR_MODE  = parity_e'(2'(PARITY));

  logic cts_meta, cts_sync, rxd_meta, rxd_sync;
  logic tick;
  logic cts_ok;

  uart_state_e          tx_state;
  logic [TCW-1:0]       tx_cnt;
  logic [2:0]           tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic [7:0]           tx_data_ext;

  uart_state_e          rx_state;
  logic [3:0]           rx_tick;
  logic [2:0]           rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_perr_pend;
  logic [7:0]           rx_data_ext;

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cts_meta <= 1'b1;
      cts_sync <= 1'b1;
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      cts_meta <= cts;
      cts_sync <= cts_meta;
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
    end
  end

  // tx_ready is registered, so it is fed from cts_meta to line up with cts_sync.
  assign cts_ok = (FLOW_CTL == 0) || cts_meta;

  always_comb begin
    tx_data_ext = '0;
    tx_data_ext[DATA_BITS-1:0] = tx_data;
    rx_data_ext = '0;
    rx_data_ext[DATA_BITS-1:0] = rx_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= ST_IDLE;
      txd      <= 1'b1;
      tx_ready <= 1'b0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
    end else begin
      case (tx_state)
        ST_IDLE: begin
          txd      <= 1'b1;
          tx_ready <= cts_ok;
          if (tx_valid && tx_ready && ((FLOW_CTL == 0) || cts_sync)) begin
            tx_shift <= tx_data;
            tx_par   <= parity_bit(tx_data_ext, PAR_MODE);
            tx_cnt   <= '0;
            tx_ready <= 1'b0;
            txd      <= 1'b0;
            tx_state <= ST_START;
          end
        end
        ST_START: begin
          if (tx_cnt == TCW'(BIT_CLKS - 1)) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            txd      <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_state <= ST_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (tx_cnt == TCW'(BIT_CLKS - 1)) begin
            tx_cnt <= '0;
            if (tx_bit == 3'(DATA_BITS - 1)) begin
              if (PAR_MODE != PAR_NONE) begin
                txd      <= tx_par;
                tx_state <= ST_PARITY;
              end else begin
                txd      <= 1'b1;
                tx_state <= ST_STOP;
              end
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              txd      <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (tx_cnt == TCW'(BIT_CLKS - 1)) begin
            tx_cnt   <= '0;
            txd      <= 1'b1;
            tx_state <= ST_STOP;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (tx_cnt == TCW'(STOP_CLKS - 1)) begin
            tx_cnt   <= '0;
            tx_ready <= cts_ok;
            tx_state <= ST_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state      <= ST_IDLE;
      rx_tick       <= '0;
      rx_bit        <= '0;
      rx_shift      <= '0;
      rx_perr_pend  <= 1'b0;
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
      rts           <= 1'b1;
    end else begin
      rx_overrun <= 1'b0;
      rts        <= (FLOW_CTL != 0) ? ~rx_valid : 1'b1;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (rx_state)
        ST_IDLE: begin
          if (!rxd_sync) begin
            rx_tick  <= '0;
            rx_state <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            if (rx_tick == 4'd7) begin
              rx_tick      <= '0;
              rx_bit       <= '0;
              rx_perr_pend <= 1'b0;
              rx_state     <= rxd_sync ? ST_IDLE : ST_DATA;
            end else begin
              rx_tick <= rx_tick + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            rx_tick <= rx_tick + 4'd1;
            if (rx_tick == 4'd15) begin
              rx_shift <= {rxd_sync, rx_shift[DATA_BITS-1:1]};
              if (rx_bit == 3'(DATA_BITS - 1)) begin
                rx_state <= (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
              end else begin
                rx_bit <= rx_bit + 1'b1;
              end
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            rx_tick <= rx_tick + 4'd1;
            if (rx_tick == 4'd15) begin
              rx_perr_pend <= rxd_sync ^ parity_bit(rx_data_ext, PAR_MODE);
              rx_state     <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            rx_tick <= rx_tick + 4'd1;
            // Leave at mid-stop so a back-to-back start edge is not missed.
            if (rx_tick == 4'd15) begin
              rx_state <= ST_IDLE;
              if (!rx_valid || rx_ready) begin
                rx_valid      <= 1'b1;
                rx_data       <= rx_shift;
                rx_parity_err <= rx_perr_pend;
                rx_frame_err  <= ~rxd_sync;
              end else begin
                rx_overrun <= 1'b1;
              end
            end
          end
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_core_param.sv
// tb/tb_uart_core_param.sv - self-checking bench: 8N1 loopback, 7E2 with flow control, 7O1 TX
module tb_uart_core_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int checks = 0;
  int errors = 0;

  // Instance A: 8N1, no flow control, optional loopback
  logic [7:0] tx_data_a, rx_data_a;
  logic tx_valid_a, tx_ready_a, txd_a, rts_a, rx_valid_a, rx_ready_a;
  logic rx_perr_a, rx_ferr_a, rx_ovr_a, loop_a;
  // Instance B: 7 data, even parity, 2 stop, flow control
  logic [6:0] tx_data_b, rx_data_b;
  logic tx_valid_b, tx_ready_b, txd_b, cts_b, rxd_b, rts_b, rx_valid_b, rx_ready_b;
  logic rx_perr_b, rx_ferr_b, rx_ovr_b;
  // Instance C: 7 data, odd parity, TX only
  logic [6:0] tx_data_c, rx_data_c;
  logic tx_valid_c, tx_ready_c, txd_c, rts_c, rx_valid_c, rx_perr_c, rx_ferr_c, rx_ovr_c;

  uart_core_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FLOW_CTL(0)) u_a (
    .clk(clk), .rst(rst), .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .txd(txd_a), .cts(1'b0), .rxd(loop_a ? txd_a : 1'b1), .rts(rts_a), .rx_data(rx_data_a),
    .rx_valid(rx_valid_a), .rx_ready(rx_ready_a), .rx_parity_err(rx_perr_a),
    .rx_frame_err(rx_ferr_a), .rx_overrun(rx_ovr_a));

  uart_core_param #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FLOW_CTL(1)) u_b (
    .clk(clk), .rst(rst), .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .txd(txd_b), .cts(cts_b), .rxd(rxd_b), .rts(rts_b), .rx_data(rx_data_b),
    .rx_valid(rx_valid_b), .rx_ready(rx_ready_b), .rx_parity_err(rx_perr_b),
    .rx_frame_err(rx_ferr_b), .rx_overrun(rx_ovr_b));

  uart_core_param #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FLOW_CTL(0)) u_c (
    .clk(clk), .rst(rst), .tx_data(tx_data_c), .tx_valid(tx_valid_c), .tx_ready(tx_ready_c),
    .txd(txd_c), .cts(1'b0), .rxd(1'b1), .rts(rts_c), .rx_data(rx_data_c),
    .rx_valid(rx_valid_c), .rx_ready(1'b1), .rx_parity_err(rx_perr_c),
    .rx_frame_err(rx_ferr_c), .rx_overrun(rx_ovr_c));

  logic [9:0] rxq_a[$];
  int ovr_a = 0;
  int ovr_b = 0;

  always @(negedge clk) begin
    if (rx_valid_a && rx_ready_a) rxq_a.push_back({rx_ferr_a, rx_perr_a, rx_data_a});
    if (rx_ovr_a) ovr_a++;
    if (rx_ovr_b) ovr_b++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Line level of bit k of a frame: start, data LSB first, optional parity, stop(s).
  function automatic logic exp_bit(input logic [7:0] d, input int dbits, input int par, input int k);
    int ones;
    ones = 0;
    if (k == 0) return 1'b0;
    if (k <= dbits) return d[k-1];
    if (par != 0 && k == dbits + 1) begin
      for (int i = 0; i < dbits; i++) ones += int'(d[i]);
      return (par == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
    end
    return 1'b1;
  endfunction

  function automatic logic get_txd(input int id);
    return (id == 0) ? txd_a : ((id == 1) ? txd_b : txd_c);
  endfunction

  function automatic logic get_ready(input int id);
    return (id == 0) ? tx_ready_a : ((id == 1) ? tx_ready_b : tx_ready_c);
  endfunction

  task automatic set_tx(input int id, input logic [7:0] d, input logic v);
    case (id)
      0:       begin tx_data_a = d;      tx_valid_a = v; end
      1:       begin tx_data_b = d[6:0]; tx_valid_b = v; end
      default: begin tx_data_c = d[6:0]; tx_valid_c = v; end
    endcase
  endtask

  task automatic send_and_check(input int id, input logic [7:0] d);
    int dbits, par, stops, nb, waited;
    dbits  = (id == 0) ? 8 : 7;
    par    = (id == 0) ? 0 : ((id == 1) ? 2 : 1);
    stops  = (id == 1) ? 2 : 1;
    nb     = 1 + dbits + ((par != 0) ? 1 : 0) + stops;
    waited = 0;
    while (get_ready(id) !== 1'b1 && waited < 2000) begin
      step(1);
      waited++;
    end
    check($sformatf("tx%0d_ready_before", id), 32'(get_ready(id)), 32'h1);
    check($sformatf("tx%0d_idle_line", id), 32'(get_txd(id)), 32'h1);
    set_tx(id, d, 1'b1);
    step(1);
    set_tx(id, d, 1'b0);
    for (int k = 0; k < nb; k++) begin
      check($sformatf("tx%0d_d%02h_bit%0d_first", id, d, k), 32'(get_txd(id)), 32'(exp_bit(d, dbits, par, k)));
      step(63);
      check($sformatf("tx%0d_d%02h_bit%0d_last", id, d, k), 32'(get_txd(id)), 32'(exp_bit(d, dbits, par, k)));
      check($sformatf("tx%0d_ready_busy%0d", id, k), 32'(get_ready(id)), 32'h0);
      step(1);
    end
    check($sformatf("tx%0d_ready_after", id), 32'(get_ready(id)), 32'h1);
  endtask

  task automatic inject_b(input logic [6:0] d, input logic bad_par, input logic bad_stop);
    int ones;
    ones = 0;
    rxd_b = 1'b0;
    step(64);
    for (int i = 0; i < 7; i++) begin
      rxd_b = d[i];
      ones += int'(d[i]);
      step(64);
    end
    rxd_b = ((ones % 2) == 1) ^ bad_par;
    step(64);
    if (bad_stop) begin
      rxd_b = 1'b0;
      step(40);
      rxd_b = 1'b1;
      step(24);
    end else begin
      rxd_b = 1'b1;
      step(64);
    end
    step(64);
  endtask

  task automatic read_b(input string tag, input logic [6:0] d, input logic pe, input logic fe);
    check({tag, "_valid"}, 32'(rx_valid_b), 32'h1);
    check({tag, "_data"}, 32'(rx_data_b), 32'(d));
    check({tag, "_perr"}, 32'(rx_perr_b), 32'(pe));
    check({tag, "_ferr"}, 32'(rx_ferr_b), 32'(fe));
    check({tag, "_rts_low"}, 32'(rts_b), 32'h0);
    rx_ready_b = 1'b1;
    step(1);
    rx_ready_b = 1'b0;
    check({tag, "_valid_clr"}, 32'(rx_valid_b), 32'h0);
    step(1);
    check({tag, "_rts_high"}, 32'(rts_b), 32'h1);
  endtask

  initial begin
    logic [7:0] lb[4];
    logic [6:0] rd;
    logic       bp, bs;
    int         base, ovr0, bad, waited;

    rst = 1'b1;
    tx_data_a = '0; tx_valid_a = 1'b0; rx_ready_a = 1'b1; loop_a = 1'b0;
    tx_data_b = '0; tx_valid_b = 1'b0; rx_ready_b = 1'b0; cts_b = 1'b1; rxd_b = 1'b1;
    tx_data_c = '0; tx_valid_c = 1'b0;
    step(3);

    check("rst_txd_a", 32'(txd_a), 32'h1);
    check("rst_tx_ready_a", 32'(tx_ready_a), 32'h0);
    check("rst_rx_valid_a", 32'(rx_valid_a), 32'h0);
    check("rst_rx_data_a", 32'(rx_data_a), 32'h0);
    check("rst_perr_a", 32'(rx_perr_a), 32'h0);
    check("rst_ferr_a", 32'(rx_ferr_a), 32'h0);
    check("rst_ovr_a", 32'(rx_ovr_a), 32'h0);
    check("rst_rts_b", 32'(rts_b), 32'h1);
    check("rst_txd_b", 32'(txd_b), 32'h1);
    rst = 1'b0;
    step(2);
    check("post_rst_ready_a", 32'(tx_ready_a), 32'h1);
    check("post_rst_ready_b", 32'(tx_ready_b), 32'h1);

    send_and_check(0, 8'hA5);
    send_and_check(1, 8'h53);
    send_and_check(2, 8'h53);
    for (int i = 0; i < 2; i++) begin
      send_and_check(0, 8'($urandom));
      send_and_check(1, 8'($urandom_range(0, 127)));
      send_and_check(2, 8'($urandom_range(0, 127)));
    end

    loop_a = 1'b1;
    rx_ready_a = 1'b1;
    lb[0] = 8'h3C; lb[1] = 8'hC3; lb[2] = 8'($urandom); lb[3] = 8'($urandom);
    base = rxq_a.size();
    for (int i = 0; i < 4; i++) send_and_check(0, lb[i]);
    check("lb_count", 32'(rxq_a.size() - base), 32'd4);
    for (int i = 0; i < 4; i++)
      if (rxq_a.size() > base + i) check($sformatf("lb_byte%0d", i), 32'(rxq_a[base+i]), 32'({2'b00, lb[i]}));

    rx_ready_a = 1'b0;
    ovr0 = ovr_a;
    send_and_check(0, 8'h11);
    send_and_check(0, 8'h22);
    check("ovr_a_valid", 32'(rx_valid_a), 32'h1);
    check("ovr_a_held", 32'(rx_data_a), 32'h11);
    check("ovr_a_pulses", 32'(ovr_a - ovr0), 32'd1);
    check("ovr_a_rts", 32'(rts_a), 32'h1);
    base = rxq_a.size();
    rx_ready_a = 1'b1;
    step(1);
    check("ovr_a_valid_clr", 32'(rx_valid_a), 32'h0);
    check("ovr_a_taken", 32'(rxq_a.size() - base), 32'd1);
    loop_a = 1'b0;

    ovr0 = ovr_b;
    inject_b(7'h11, 1'b0, 1'b0);
    check("ovr_b_first_valid", 32'(rx_valid_b), 32'h1);
    check("ovr_b_rts", 32'(rts_b), 32'h0);
    inject_b(7'h22, 1'b0, 1'b0);
    check("ovr_b_pulses", 32'(ovr_b - ovr0), 32'd1);
    read_b("ovr_b_held", 7'h11, 1'b0, 1'b0);

    rxd_b = 1'b0;
    step(20);
    rxd_b = 1'b1;
    step(200);
    check("glitch_no_valid", 32'(rx_valid_b), 32'h0);

    inject_b(7'h5A, 1'b0, 1'b1);
    read_b("ferr", 7'h5A, 1'b0, 1'b1);
    inject_b(7'h33, 1'b1, 1'b0);
    read_b("perr", 7'h33, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      rd = 7'($urandom_range(0, 127));
      bp = ($urandom_range(0, 3) == 0);
      bs = ($urandom_range(0, 3) == 0);
      inject_b(rd, bp, bs);
      read_b($sformatf("rand%0d", i), rd, bp, bs);
    end

    cts_b = 1'b0;
    step(3);
    check("cts_low_ready", 32'(tx_ready_b), 32'h0);
    tx_data_b = 7'h4B;
    tx_valid_b = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (txd_b !== 1'b1 || tx_ready_b !== 1'b0) bad++;
    end
    check("cts_low_hold", 32'(bad), 32'd0);
    cts_b = 1'b1;
    waited = 0;
    while (tx_ready_b !== 1'b1 && waited < 3) begin
      step(1);
      waited++;
    end
    check("cts_resume_ready", 32'(tx_ready_b), 32'h1);
    step(1);
    tx_valid_b = 1'b0;
    check("cts_resume_start", 32'(txd_b), 32'h0);
    cts_b = 1'b0;
    step(70);
    check("cts_drop_no_abort", 32'(txd_b), 32'(exp_bit(8'h4B, 7, 2, 1)));
    step(30);
    rst = 1'b1;
    step(1);
    check("midframe_rst_txd", 32'(txd_b), 32'h1);
    check("midframe_rst_ready", 32'(tx_ready_b), 32'h0);
    rst = 1'b0;
    cts_b = 1'b1;
    step(2);
    check("after_rst_ready", 32'(tx_ready_b), 32'h1);
    check("after_rst_txd", 32'(txd_b), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
Parametrised full-duplex UART core, the successor to the fixed 8N1 controller. It provides configurable data width, parity and stop bits, a 16x-oversampled receiver with false-start rejection, and valid/ready handshakes on both byte interfaces. Optional RTS/CTS hardware flow control is included. It sits between the host-side byte logic and the board serial pins, and it generates its own baud tick internally.

Parameters:
CLK_DIV, 4, clk cycles per oversample tick (must be >= 2); bit period BIT_CLKS = CLK_DIV*16
DATA_BITS, 8, data bits per frame, 5..8
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2 (TX only; RX checks the first stop bit)
FLOW_CTL, 0, 1 = honour cts and drive rts; 0 = ignore cts and tie rts=1

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
tx_data  in  DATA_BITS  byte to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  transmitter accepts tx_data this cycle
txd  out  1  serial output, idle high
cts  in  1  peer ready to receive (async, active-high)
rxd  in  1  serial input (async)
rts  out  1  this core ready to receive (active-high)
rx_data  out  DATA_BITS  received byte
rx_valid  out  1  rx_data and error flags held valid
rx_ready  in  1  consumer takes rx_data
rx_parity_err  out  1  parity mismatch on held byte
rx_frame_err  out  1  stop bit sampled 0 on held byte
rx_overrun  out  1  one-cycle pulse: frame dropped because holding register full

Behaviour:
- Reset values (all outputs registered): txd=1, tx_ready=0 for the reset cycle (then follows the rule below), rx_valid=0, rx_data=0, err flags=0, rx_overrun=0, rts=1. Synchronisers reset to 1.
- rxd and cts each pass through a 2-flop synchroniser before use.
- Tick generator: counter 0..CLK_DIV-1; tick pulse when count==CLK_DIV-1; free-running from reset. Only RX uses it.
- TX FSM, states IDLE/START/DATA/PARITY/STOP:
  - tx_ready=1 only in IDLE and (FLOW_CTL==0 or cts_sync==1).
  - Transfer on tx_valid&tx_ready: data is latched, START is entered next cycle, and txd=0 from that cycle.
  - Each bit lasts exactly BIT_CLKS cycles, timed by a TX-local clock counter, not the tick.
  - Data is sent LSB first. PARITY state only if PARITY!=0: odd gives XNOR-reduce, even gives XOR-reduce.
  - STOP lasts STOP_BITS*BIT_CLKS cycles with txd=1, then IDLE.
  - cts is sampled only in IDLE; deasserting it mid-frame does not abort the frame.
- RX FSM, states IDLE/START/DATA/PARITY/STOP, with a tick counter 0..15 per bit:
  - IDLE: rxd_sync==0 enters START with tick count cleared.
  - START: after 8 ticks, resample. 0 goes to DATA; 1 returns to IDLE (false start, nothing reported).
  - DATA/PARITY/STOP: sample every 16 ticks (mid-bit), shifting LSB first.
  - STOP sample: frame_err = ~sample. Return to IDLE at the mid-stop sample so the next start edge can be detected.
  - On completion: if rx_valid==0 (or is being cleared this same cycle by rx_ready), load rx_data and the err flags and set rx_valid=1 on the next cycle. Otherwise drop the frame, keep the held byte, and pulse rx_overrun for 1 cycle.
  - rx_valid clears the cycle after rx_valid&rx_ready.
- rts (FLOW_CTL=1): registered ~rx_valid, so it drops the cycle after rx_valid rises.
- Simultaneous events: RX completion together with rx_ready → new byte loaded, no overrun. TX accept and RX completion are independent.
- Reset mid-frame: both FSMs go to IDLE and txd=1 the cycle after rst. Partial frames are discarded.

Decomposition:
- Package uart_pkg: parity enum (PAR_NONE/PAR_ODD/PAR_EVEN), shared FSM state enum, OVERSAMPLE=16, and a function parity_bit(data, mode).
- One sub-module uart_baud_tick (CLK_DIV parameter; clk, rst, tick out).
- TX and RX remain as always-blocks within the core.

Test Plan:
- CLK_DIV=4, 8N1: send 0xA5 → txd = 0,1,0,1,0,0,1,0,1, then 1, each level held 64 cycles. tx_ready low 640 cycles and high again at cycle 641.
- PARITY=2, 7 data bits: send 0x53 (four ones) → parity bit 0. PARITY=1 → parity bit 1.
- Loop txd→rxd, send 0x3C then 0xC3 with rx_ready=1 → rx_data 0x3C then 0xC3, no error flags.
- rx_ready=0, inject two frames 0x11, 0x22 → rx_data stays 0x11, rx_overrun pulses once at the second stop mid-sample. With FLOW_CTL=1, rts=0 after the first frame.
- Glitch rxd low for 5 ticks (20 cycles) → no rx_valid. Frame with stop=0 → rx_valid=1 with rx_frame_err=1. Frame with wrong parity → rx_parity_err=1.
- FLOW_CTL=1, cts=0 with tx_valid=1 → txd stays 1 and tx_ready=0. Raise cts → transfer within 3 cycles. Assert rst mid-data-bit → txd=1 next cycle, tx_ready=1 after reset.
